// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pulls bytes from an upstream FIFO and transmits each one as an 8N1 serial
// frame: one start bit (low), eight data bits LSB first, one stop bit (high).
// The line idles high. Each serial bit lasts CLKS_PER_BIT clock cycles.
//
// Flow per byte:
//   IDLE  : when enable_in=1 and the FIFO is not empty, pulse rd_en_out for
//           this cycle and move to WAIT.
//   WAIT  : wait up to 4 cycles for data_valid_in. On valid, capture data_in
//           and start the frame; if it never arrives, give up and go to IDLE.
//   START : line low for one bit time.
//   DATA  : eight data bits, LSB first.
//   STOP  : line high for one bit time; byte_done_out pulses on its last cycle.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (legal range >= 2)
//   DEPTH         upstream FIFO depth; occupancy is $clog2(DEPTH)+1 bits wide
//
// Ports
//   clk_in         in   system clock, rising edge
//   rst_in         in   asynchronous, active-high reset
//   enable_in      in   permits new FIFO reads when high
//   occupancy_in   in   upstream FIFO occupancy
//   data_in        in   upstream FIFO read data
//   data_valid_in  in   upstream FIFO read-data valid strobe
//   rd_en_out      out  FIFO pop request, single-cycle pulse
//   tx_out         out  registered serial line, idle high
//   busy_out       out  high whenever the FSM is not in IDLE
//   byte_done_out  out  one-cycle pulse on the final cycle of a stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic [$clog2(DEPTH):0] occupancy_in,
  input  logic [7:0]             data_in,
  input  logic                   data_valid_in,
  output logic                   rd_en_out,
  output logic                   tx_out,
  output logic                   busy_out,
  output logic                   byte_done_out
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  // WAIT gives up after its fourth cycle without a valid strobe.
  localparam logic [1:0]        WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q,  baud_d;
  logic [2:0]          bit_q,   bit_d;
  logic [1:0]          wait_q,  wait_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q,    tx_d;

  logic                rd_req;
  logic                baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // A read is requested only from IDLE with data available. The rst_in term
  // keeps the pop strobe low while reset is held, without waiting for an edge.
  assign rd_req = (state_q == ST_IDLE) && enable_in &&
                  (occupancy_in != '0) && !rst_in;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: the shift register is a handful of flops, not a memory array, so it
  // is reset along with the rest; a byte interrupted by reset is dropped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      wait_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // tx_d is the line level for the *next* cycle, so tx_out comes straight off
  // a flop and lines up exactly with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        wait_d = '0;
        tx_d   = 1'b1;
        if (rd_req) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tx_d = 1'b1;
        if (data_valid_in) begin
          shift_d = data_in;
          wait_d  = '0;
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            // Shift right so the next bit to send is always at index 0.
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        wait_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_en_out     = rd_req;
  assign tx_out        = tx_q;
  assign busy_out      = (state_q != ST_IDLE);
  assign byte_done_out = (state_q == ST_STOP) && baud_last;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. Each entry of the
// vector queue is one clock cycle: the inputs to drive and the outputs
// expected for that cycle. Inputs are driven on the falling edge and outputs
// are compared 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       enable_in;
  logic [3:0] occupancy_in;
  logic [7:0] data_in;
  logic       data_valid_in;
  logic       rd_en_out;
  logic       tx_out;
  logic       busy_out;
  logic       byte_done_out;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] occ;
    logic [7:0] data;
    logic       valid;
    logic       exp_rd;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vq[$];

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable_in     (enable_in),
    .occupancy_in  (occupancy_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .rd_en_out     (rd_en_out),
    .tx_out        (tx_out),
    .busy_out      (busy_out),
    .byte_done_out (byte_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void push(input logic rst, input logic en, input logic [3:0] occ,
                               input logic [7:0] data, input logic valid,
                               input logic rd, input logic tx, input logic busy,
                               input logic done);
    vec_t v;
    v.rst = rst; v.en = en; v.occ = occ; v.data = data; v.valid = valid;
    v.exp_rd = rd; v.exp_tx = tx; v.exp_busy = busy; v.exp_done = done;
    vq.push_back(v);
  endfunction

  // IDLE cycle that pops the FIFO, then the WAIT cycle where valid data returns.
  function automatic void add_fetch(input logic [3:0] occ_idle, input logic [3:0] occ_wait,
                                    input logic [7:0] data);
    push(1'b0, 1'b1, occ_idle, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, occ_wait, data,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  // One full 8N1 frame, at most max_cyc cycles of it. enable_in drops at the
  // start of data bit drop_bit (8 = never). During START a spurious valid
  // with different data is driven; it must be ignored.
  function automatic void add_frame(input logic [7:0] data, input logic [3:0] occ,
                                    input int drop_bit, input int max_cyc);
    int n = 0;
    for (int c = 0; c < CPB; c++) begin
      if (n < max_cyc) push(1'b0, 1'b1, occ, ~data, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (n < max_cyc) push(1'b0, (b < drop_bit), occ, 8'h00, 1'b0,
                              1'b0, data[b], 1'b1, 1'b0);
        n++;
      end
    end
    for (int c = 0; c < CPB; c++) begin
      if (n < max_cyc) push(1'b0, (drop_bit >= 8), occ, 8'h00, 1'b0,
                            1'b0, 1'b1, 1'b1, (c == CPB - 1));
      n++;
    end
  endfunction

  // Idle cycles where no read may happen (enable low or FIFO empty).
  function automatic void add_idle(input int n, input logic en, input logic [3:0] occ,
                                   input logic valid);
    for (int i = 0; i < n; i++) begin
      push(1'b0, en, occ, 8'h5A, valid, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endfunction

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_in);
      rst_in        = vq[i].rst;
      enable_in     = vq[i].en;
      occupancy_in  = vq[i].occ;
      data_in       = vq[i].data;
      data_valid_in = vq[i].valid;
      #1;
      check($sformatf("%s[%0d].rd_en",  tag, i), {7'd0, rd_en_out},     {7'd0, vq[i].exp_rd});
      check($sformatf("%s[%0d].tx",     tag, i), {7'd0, tx_out},        {7'd0, vq[i].exp_tx});
      check($sformatf("%s[%0d].busy",   tag, i), {7'd0, busy_out},      {7'd0, vq[i].exp_busy});
      check($sformatf("%s[%0d].done",   tag, i), {7'd0, byte_done_out}, {7'd0, vq[i].exp_done});
    end
    vq.delete();
  endtask

  initial begin
    rst_in        = 1'b0;
    enable_in     = 1'b1;
    occupancy_in  = 4'd1;
    data_in       = 8'h00;
    data_valid_in = 1'b0;

    // Reset asserted before the first clock edge: outputs must respond at once.
    #2 rst_in = 1'b1;
    #1;
    check("por.tx",   {7'd0, tx_out},        8'd1);
    check("por.busy", {7'd0, busy_out},      8'd0);
    check("por.rd",   {7'd0, rd_en_out},     8'd0);
    check("por.done", {7'd0, byte_done_out}, 8'd0);

    // Single byte 0xA5; read fires in the first IDLE cycle after release.
    push(1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_fetch(4'd1, 4'd0, 8'hA5);
    add_frame(8'hA5, 4'd0, 8, 40);
    add_idle(3, 1'b1, 4'd0, 1'b1);
    run_vectors("single");

    // Back-to-back 0x00 then 0xFF: stop(4) + IDLE + WAIT = 6 high cycles between.
    add_fetch(4'd2, 4'd1, 8'h00);
    add_frame(8'h00, 4'd1, 8, 40);
    add_fetch(4'd1, 4'd0, 8'hFF);
    add_frame(8'hFF, 4'd0, 8, 40);
    add_idle(3, 1'b1, 4'd0, 1'b0);
    run_vectors("b2b");

    // WAIT timeout: four WAIT cycles, then IDLE re-pulses rd_en.
    push(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_idle(3, 1'b0, 4'd1, 1'b0);
    run_vectors("timeout");

    // Enable gating: no reads while disabled; dropping enable mid-byte
    // (data bit 3) lets the byte finish and blocks further reads.
    add_idle(100, 1'b0, 4'd3, 1'b0);
    add_fetch(4'd3, 4'd2, 8'h3C);
    add_frame(8'h3C, 4'd2, 3, 40);
    add_idle(10, 1'b0, 4'd2, 1'b0);
    run_vectors("gate");

    // Reset mid-byte: 0x55 has bit 3 = 0, so the line is low when reset hits.
    add_fetch(4'd1, 4'd1, 8'h55);
    add_frame(8'h55, 4'd1, 8, 17);
    run_vectors("pre_rst");
    @(negedge clk_in);
    #1;
    check("midrst.tx_before", {7'd0, tx_out}, 8'd0);
    #1 rst_in = 1'b1;
    #1;
    check("midrst.tx",   {7'd0, tx_out},        8'd1);
    check("midrst.busy", {7'd0, busy_out},      8'd0);
    check("midrst.rd",   {7'd0, rd_en_out},     8'd0);
    check("midrst.done", {7'd0, byte_done_out}, 8'd0);

    // After release the next byte goes out as a complete, correct frame.
    push(1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_fetch(4'd1, 4'd0, 8'hC3);
    add_frame(8'hC3, 4'd0, 8, 40);
    add_idle(3, 1'b1, 4'd0, 1'b0);
    run_vectors("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (legal range >= 2).
REQ-002 SHALL have parameter DEPTH, default 8, depth of the upstream FIFO; sets the occupancy width to $clog2(DEPTH)+1.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable_in  input  1  permits new FIFO reads when high.
REQ-006 SHALL have port occupancy_in  input  $clog2(DEPTH)+1  upstream FIFO occupancy.
REQ-007 SHALL have port data_in  input  8  upstream FIFO read data.
REQ-008 SHALL have port data_valid_in  input  1  upstream FIFO read-data valid strobe.
REQ-009 SHALL have port rd_en_out  output  1  FIFO pop request, single-cycle pulse.
REQ-010 SHALL have port tx_out  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-012 SHALL have port byte_done_out  output  1  one-cycle pulse on completion of a stop bit.

Function
REQ-013 SHALL implement states IDLE, WAIT, START, DATA and STOP.
REQ-014 SHALL, in IDLE with enable_in=1 and occupancy_in>0, assert rd_en_out for exactly that cycle and go to WAIT.
REQ-015 SHALL never assert rd_en_out when occupancy_in==0, when enable_in==0, or outside IDLE.
REQ-016 SHALL, in WAIT, on data_valid_in=1 latch data_in into a shift register and go to START on the next edge.
REQ-017 SHALL, if data_valid_in is not seen within 4 WAIT cycles, return to IDLE with no byte sent and no byte_done_out pulse.
REQ-018 SHALL ignore data_valid_in in every state except WAIT.
REQ-019 SHALL drive tx_out=0 for exactly CLKS_PER_BIT cycles in START.
REQ-020 SHALL drive the 8 data bits in DATA, LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-021 SHALL drive tx_out=1 for exactly CLKS_PER_BIT cycles in STOP.
REQ-022 SHALL drive tx_out=1 in IDLE and WAIT.
REQ-023 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1, clears on every bit boundary, and never wraps mid-bit.
REQ-024 SHALL use a 3-bit bit index 0..7 and leave DATA after index 7 completes.
REQ-025 SHALL, on the final STOP cycle, pulse byte_done_out and return to IDLE.
REQ-026 SHALL, for back-to-back bytes, produce IDLE (rd_en_out) -> WAIT (valid) -> START, giving exactly 2 extra idle-high cycles between the end of the stop bit and the next start bit.
REQ-027 SHALL, if enable_in falls mid-byte, finish the current byte unchanged and issue no further reads.
REQ-028 SHALL register tx_out so it is glitch-free.

Reset
REQ-029 SHALL, on rst_in high, immediately and regardless of clock set state=IDLE, tx_out=1, rd_en_out=0, busy_out=0, byte_done_out=0, counters=0 and shift register=0x00.
REQ-030 SHALL, on reset during a byte, abandon that byte; the partially sent byte is not retried.
REQ-031 SHALL allow a new read in the first IDLE cycle after rst_in deasserts, provided enable_in=1 and occupancy_in>0.

Verification
REQ-032 SHALL verify reset (CLKS_PER_BIT=4): assert rst_in between clock edges -> tx_out=1, busy_out=0 and rd_en_out=0 without waiting for a clock edge.
REQ-033 SHALL verify a single byte: occupancy_in=1, valid with 0xA5 one cycle after rd_en_out -> one rd_en_out pulse; tx_out = 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles (40 cycles total); byte_done_out pulses once.
REQ-034 SHALL verify back-to-back bytes: 0x00 then 0xFF with occupancy_in 2 -> 1 -> two frames, with the line high for 4+2 cycles between them, and exactly two rd_en_out pulses.
REQ-035 SHALL verify the WAIT timeout: occupancy_in=1 and data_valid_in held low -> return to IDLE after 4 WAIT cycles, tx_out stays 1, and rd_en_out re-pulses on the next IDLE cycle.
REQ-036 SHALL verify enable gating: enable_in=0 with occupancy_in=3 -> no rd_en_out for 100 cycles; dropping enable_in during data bit 3 -> the byte completes and no further rd_en_out occurs.
REQ-037 SHALL verify reset mid-byte: rst_in during data bit 3 -> tx_out=1 immediately; after release with occupancy_in=1, the next byte is sent as a complete, correct frame.
